alt_ddrx_bank_sched: RTL and testbench



---
 rtl/alt_ddrx_bank_sched.sv | 174 +++++++++++++++++
 tb/tb_alt_ddrx_bank_sched.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/alt_ddrx_bank_sched.sv
// alt_ddrx_bank_sched: open-row-tracking DDR command scheduler with ACT/PRE insertion and auto-refresh.
// The first command of a request is issued from IDLE on the accept edge; later ones issue when wait_cnt drains.
module alt_ddrx_bank_sched #(
    parameter int MEM_IF_CS_WIDTH  = 1,
    parameter int MEM_IF_BA_WIDTH  = 3,
    parameter int MEM_IF_ROW_WIDTH = 13,
    parameter int MEM_IF_COL_WIDTH = 10,
    parameter int T_RCD            = 3,
    parameter int T_RP             = 3,
    parameter int T_RFC            = 30,
    parameter int T_CCD            = 2,
    parameter int T_REFI           = 1560
) (
    input  logic                        ctl_clk,
    input  logic                        ctl_reset_n,
    input  logic                        ctl_cal_success,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [MEM_IF_BA_WIDTH-1:0]  cmd_bank,
    input  logic [MEM_IF_ROW_WIDTH-1:0] cmd_row,
    input  logic [MEM_IF_COL_WIDTH-1:0] cmd_col,
    output logic                        do_write,
    output logic                        do_read,
    output logic                        do_activate,
    output logic                        do_precharge,
    output logic                        do_precharge_all,
    output logic                        do_refresh,
    output logic                        do_auto_precharge,
    output logic                        do_burst_chop,
    output logic                        do_power_down,
    output logic                        do_self_rfsh,
    output logic                        do_lmr,
    output logic                        do_zqcal,
    output logic [MEM_IF_CS_WIDTH-1:0]  to_chip,
    output logic [MEM_IF_BA_WIDTH-1:0]  to_bank_addr,
    output logic [MEM_IF_ROW_WIDTH-1:0] to_row_addr,
    output logic [MEM_IF_COL_WIDTH-1:0] to_col_addr
);
    localparam int NB = 1 << MEM_IF_BA_WIDTH;
    localparam logic [15:0] RCD_L  = 16'(T_RCD - 1);
    localparam logic [15:0] RP_L   = 16'(T_RP - 1);
    localparam logic [15:0] RFC_L  = 16'(T_RFC - 1);
    localparam logic [15:0] CCD_L  = 16'(T_CCD - 1);
    localparam logic [15:0] REFI_L = 16'(T_REFI - 1);

    typedef enum logic [2:0] {INIT, IDLE, PRE, ACT, RW, PREALL, REF} state_t;
    typedef enum logic [2:0] {C_NONE, C_RW, C_ACT, C_PRE, C_PREALL, C_REF} cmd_t;

    state_t                              state_q, state_d;
    cmd_t                                issue;
    logic [15:0]                         wait_q, wait_d, refi_q, refi_d;
    logic                                pend_q, pend_d, ready_q, ready_d, acc, w, hit;
    logic [NB-1:0]                       open_q, open_d;
    logic [NB-1:0][MEM_IF_ROW_WIDTH-1:0] orow_q, orow_d;
    logic                                req_w_q, req_w_d;
    logic [MEM_IF_BA_WIDTH-1:0]          req_b_q, req_b_d, bank_q, bank_d, b;
    logic [MEM_IF_ROW_WIDTH-1:0]         req_r_q, req_r_d, row_q, row_d, r;
    logic [MEM_IF_COL_WIDTH-1:0]         req_c_q, req_c_d, col_q, col_d, c;
    logic [5:0]                          strobe_q, strobe_d;
    logic [MEM_IF_CS_WIDTH-1:0]          chip_q, chip_d;

    always_comb begin
        acc     = cmd_valid & ready_q;
        w       = acc ? cmd_write : req_w_q;
        b       = acc ? cmd_bank : req_b_q;
        r       = acc ? cmd_row : req_r_q;
        c       = acc ? cmd_col : req_c_q;
        hit     = open_q[b] & (orow_q[b] == r);
        req_w_d = w;
        req_b_d = b;
        req_r_d = r;
        req_c_d = c;
        state_d = state_q;
        wait_d  = (wait_q == '0) ? '0 : wait_q - 16'd1;
        refi_d  = (refi_q == '0) ? REFI_L : refi_q - 16'd1;
        pend_d  = pend_q | (refi_q == '0);
        open_d  = open_q;
        orow_d  = orow_q;
        bank_d  = bank_q;
        row_d   = row_q;
        col_d   = col_q;
        issue   = C_NONE;
        case (state_q)
            INIT:    state_d = IDLE;
            IDLE:    issue = (wait_q != '0) ? C_NONE :
                             acc ? (hit ? C_RW : open_q[b] ? C_PRE : C_ACT) :
                             pend_q ? ((|open_q) ? C_PREALL : C_REF) : C_NONE;
            PRE:     issue = (wait_q == '0) ? C_ACT : C_NONE;
            ACT:     issue = (wait_q == '0) ? C_RW : C_NONE;
            PREALL:  issue = (wait_q == '0) ? C_REF : C_NONE;
            default: state_d = (wait_q == '0) ? IDLE : state_q;
        endcase
        case (issue)
            C_RW:     begin state_d = RW;     wait_d = CCD_L; end
            C_ACT:    begin state_d = ACT;    wait_d = RCD_L; open_d[b] = 1'b1; orow_d[b] = r; end
            C_PRE:    begin state_d = PRE;    wait_d = RP_L;  open_d[b] = 1'b0; end
            C_PREALL: begin state_d = PREALL; wait_d = RP_L; end
            C_REF:    begin state_d = REF;    wait_d = RFC_L; open_d = '0; pend_d = 1'b0; end
            default:  ;
        endcase
        if (issue inside {C_RW, C_ACT, C_PRE}) {bank_d, row_d, col_d} = {b, r, c};
        strobe_d = {issue == C_REF, issue == C_PREALL, issue == C_PRE, issue == C_ACT,
                    issue == C_RW & !w, issue == C_RW & w};
        chip_d   = {MEM_IF_CS_WIDTH{issue != C_NONE}};
        if (!ctl_cal_success) begin
            state_d  = INIT;
            strobe_d = '0;
            chip_d   = '0;
            open_d   = '0;
            pend_d   = 1'b0;
            wait_d   = '0;
            refi_d   = REFI_L;
        end
        // INIT term delays ready by one cycle after calibration completes
        ready_d = (state_q != INIT) & (state_d == IDLE) & (wait_d == '0) & !pend_d;
    end

    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            state_q  <= INIT;
            wait_q   <= '0;
            refi_q   <= REFI_L;
            pend_q   <= 1'b0;
            ready_q  <= 1'b0;
            open_q   <= '0;
            orow_q   <= '0;
            req_w_q  <= 1'b0;
            req_b_q  <= '0;
            req_r_q  <= '0;
            req_c_q  <= '0;
            bank_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            strobe_q <= '0;
            chip_q   <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            refi_q   <= refi_d;
            pend_q   <= pend_d;
            ready_q  <= ready_d;
            open_q   <= open_d;
            orow_q   <= orow_d;
            req_w_q  <= req_w_d;
            req_b_q  <= req_b_d;
            req_r_q  <= req_r_d;
            req_c_q  <= req_c_d;
            bank_q   <= bank_d;
            row_q    <= row_d;
            col_q    <= col_d;
            strobe_q <= strobe_d;
            chip_q   <= chip_d;
        end
    end

    assign cmd_ready         = ready_q;
    assign do_write          = strobe_q[0];
    assign do_read           = strobe_q[1];
    assign do_activate       = strobe_q[2];
    assign do_precharge      = strobe_q[3];
    assign do_precharge_all  = strobe_q[4];
    assign do_refresh        = strobe_q[5];
    assign do_auto_precharge = 1'b0;
    assign do_burst_chop     = 1'b0;
    assign do_power_down     = 1'b0;
    assign do_self_rfsh      = 1'b0;
    assign do_lmr            = 1'b0;
    assign do_zqcal          = 1'b0;
    assign to_chip           = chip_q;
    assign to_bank_addr      = bank_q;
    assign to_row_addr       = row_q;
    assign to_col_addr       = col_q;
endmodule

// File: tb/tb_alt_ddrx_bank_sched.sv
// tb_alt_ddrx_bank_sched: table-driven requests plus refresh and calibration-loss sequences,
// checked by a scoreboard of expected strobes with their exact cycles and address fields.
module tb_alt_ddrx_bank_sched;
    localparam int RCD = 3, RP = 3, RFC = 30, CCD = 2, REFI = 200;
    localparam int K_WR = 1, K_RD = 2, K_ACT = 3, K_PRE = 4, K_PALL = 5, K_REF = 6;

    typedef struct {
        logic        w;
        logic [2:0]  b;
        logic [12:0] r;
        logic [9:0]  c;
        int          cs;
    } vec_t;
    typedef struct {
        int          cyc;
        int          kind;
        logic [2:0]  b;
        logic [12:0] r;
        logic [9:0]  c;
    } ev_t;

    logic        clk = 1'b0, rst_n, cal, cmd_valid, cmd_ready, cmd_write;
    logic [2:0]  cmd_bank;
    logic [12:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        do_write, do_read, do_activate, do_precharge, do_precharge_all, do_refresh;
    logic        do_auto_precharge, do_burst_chop, do_power_down, do_self_rfsh, do_lmr, do_zqcal;
    logic [0:0]  to_chip;
    logic [2:0]  to_bank_addr;
    logic [12:0] to_row_addr;
    logic [9:0]  to_col_addr;

    ev_t  q[$];
    vec_t tv[9];
    int   total = 0, bad = 0, cyc = 0, exp_ready = -1;

    alt_ddrx_bank_sched #(
        .T_RCD(RCD), .T_RP(RP), .T_RFC(RFC), .T_CCD(CCD), .T_REFI(REFI)
    ) dut (
        .ctl_clk(clk), .ctl_reset_n(rst_n), .ctl_cal_success(cal),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
        .do_write(do_write), .do_read(do_read), .do_activate(do_activate),
        .do_precharge(do_precharge), .do_precharge_all(do_precharge_all), .do_refresh(do_refresh),
        .do_auto_precharge(do_auto_precharge), .do_burst_chop(do_burst_chop),
        .do_power_down(do_power_down), .do_self_rfsh(do_self_rfsh), .do_lmr(do_lmr), .do_zqcal(do_zqcal),
        .to_chip(to_chip), .to_bank_addr(to_bank_addr), .to_row_addr(to_row_addr), .to_col_addr(to_col_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic void add(input int cy, input int k, input vec_t v);
        ev_t e;
        e.cyc = cy; e.kind = k; e.b = v.b; e.r = v.r; e.c = v.c;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        logic [5:0] s;
        ev_t e;
        int k;
        s = {do_refresh, do_precharge_all, do_precharge, do_activate, do_read, do_write};
        chk("tied_zero", {do_auto_precharge, do_burst_chop, do_power_down, do_self_rfsh, do_lmr, do_zqcal}, 0);
        if (s != 6'd0) begin
            chk("one_strobe", $countones(s), 1);
            chk("to_chip_on", to_chip, 1);
            k = s[0] ? K_WR : s[1] ? K_RD : s[2] ? K_ACT : s[3] ? K_PRE : s[4] ? K_PALL : K_REF;
            if (q.size() == 0) chk("unexpected_strobe", k, 0);
            else begin
                e = q.pop_front();
                chk("strobe_kind", k, e.kind);
                chk("strobe_cycle", cyc, e.cyc);
                if (e.kind <= K_PRE)
                    chk("strobe_fields", {to_bank_addr, to_row_addr, to_col_addr}, {e.b, e.r, e.c});
            end
        end else chk("to_chip_idle", to_chip, 0);
    end

    task automatic send(input vec_t v, output int a);
        int n = 0;
        int rwc;
        int rwk;
        @(negedge clk);
        {cmd_write, cmd_bank, cmd_row, cmd_col} = {v.w, v.b, v.r, v.c};
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        a = cyc;
        if (!cmd_ready) begin
            chk("ready_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        if (exp_ready >= 0) chk("ready_cycle", cyc, exp_ready);
        rwk = v.w ? K_WR : K_RD;
        case (v.cs)
            0: rwc = a + 1;
            1: begin add(a + 1, K_ACT, v); rwc = a + 1 + RCD; end
            default: begin add(a + 1, K_PRE, v); add(a + 1 + RP, K_ACT, v); rwc = a + 1 + RP + RCD; end
        endcase
        add(rwc, rwk, v);
        exp_ready = rwc + CCD;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rp, a;
        vec_t z;
        z = '{1'b0, 3'd0, 13'd0, 10'd0, 0};
        tv = '{
            '{1'b0, 3'd2, 13'h0123, 10'h040, 1},
            '{1'b1, 3'd2, 13'h0123, 10'h041, 0},
            '{1'b0, 3'd2, 13'h0055, 10'h042, 2},
            '{1'b1, 3'd0, 13'h0000, 10'h000, 1},
            '{1'b0, 3'd7, 13'h1FFF, 10'h3FF, 1},
            '{1'b1, 3'd7, 13'h1FFF, 10'h001, 0},
            '{1'b0, 3'd0, 13'h1FFF, 10'h3FF, 2},
            '{1'b1, 3'd0, 13'h1FFF, 10'h010, 0},
            '{1'b0, 3'd2, 13'h0055, 10'h3FE, 0}
        };
        rst_n = 1'b0; cal = 1'b0; cmd_valid = 1'b0;
        cmd_write = 1'b0; cmd_bank = '0; cmd_row = '0; cmd_col = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_chip", to_chip, 0);
        chk("rst_fields", {to_bank_addr, to_row_addr, to_col_addr}, 0);
        chk("rst_strobes", {do_write, do_read, do_activate, do_precharge, do_precharge_all, do_refresh}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("ready_no_cal", cmd_ready, 0);
        cal = 1'b1;
        c0 = cyc;
        exp_ready = c0 + 2;
        foreach (tv[i]) send(tv[i], a);
        drain();

        rp = c0 + REFI;
        add(rp + 1, K_PALL, z);
        add(rp + 1 + RP, K_REF, z);
        while (cyc < rp - 1) @(negedge clk);
        chk("ready_before_refresh", cmd_ready, 1);
        exp_ready = rp + 1 + RP + RFC;
        send('{1'b0, 3'd0, 13'h1FFF, 10'h2AA, 1}, a);
        drain();

        send('{1'b0, 3'd3, 13'h0ABC, 10'h015, 1}, a);
        void'(q.pop_back());
        @(negedge clk);
        @(negedge clk);
        cal = 1'b0;
        repeat (8) @(negedge clk);
        chk("ready_cal_low", cmd_ready, 0);
        chk("act_before_drop", q.size(), 0);
        cal = 1'b1;
        exp_ready = cyc + 2;
        send('{1'b0, 3'd3, 13'h0ABC, 10'h015, 1}, a);
        send('{1'b1, 3'd0, 13'h1FFF, 10'h2AB, 1}, a);
        drain();
        repeat (10) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
